// File: rtl/seg7_scan_driver.sv
// Multiplexed hex seven-segment scanner: one digit per scan_clk rising edge, anode-off gap between digits.
// Latency: outputs registered; digit off at E+1, new digit from E+1+GHOST. No backpressure (free-running display).
module seg7_scan_driver #(
  parameter int DIGITS      = 8,
  parameter int GHOST       = 4,
  parameter bit LZ_SUPPRESS = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_clk,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic [7:0]  blank,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n
);

  localparam int CW = (GHOST > 1) ? $clog2(GHOST) : 1;

  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          scan_clk_q;
  logic          tick;
  logic [31:0]   data_q, data_d;
  logic [7:0]    dp_q, dp_d;
  logic [7:0]    blank_q, blank_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_n_q, dp_n_d;
  logic [7:0]    lz;
  logic          zero_run;
  logic [3:0]    nib;
  logic          show;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0:    decode = 7'b1000000;
      4'h1:    decode = 7'b1111001;
      4'h2:    decode = 7'b0100100;
      4'h3:    decode = 7'b0110000;
      4'h4:    decode = 7'b0011001;
      4'h5:    decode = 7'b0010010;
      4'h6:    decode = 7'b0000010;
      4'h7:    decode = 7'b1111000;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0010000;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b0000011;
      4'hC:    decode = 7'b1000110;
      4'hD:    decode = 7'b0100001;
      4'hE:    decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  assign tick = scan_clk & ~scan_clk_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    if (tick) begin
      if (state_q == IDLE) idx_d = 3'd0;
      else                 idx_d = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
      // Snapshot only at frame start so a mid-frame data change never tears.
      if (idx_d == 3'd0) begin
        data_d  = data;
        dp_d    = dp;
        blank_d = blank;
      end
      state_d = (GHOST == 0) ? SHOW : GAP;
      cnt_d   = (GHOST > 0) ? CW'(GHOST - 1) : '0;
    end else if (state_q == GAP) begin
      if (cnt_q == '0) state_d = SHOW;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  // Outputs are decoded from next-state values so the registered pins line up with the state.
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (i < DIGITS) begin
        zero_run = zero_run & (data_d[4*i +: 4] == 4'h0);
        lz[i]    = zero_run & (i > 0);
      end
    end
    nib    = data_d[{idx_d, 2'b00} +: 4];
    show   = (state_d == SHOW) && !blank_d[idx_d] && !(LZ_SUPPRESS && lz[idx_d]);
    an_d   = show ? ~(8'b1 << idx_d) : 8'hFF;
    seg_d  = show ? decode(nib) : 7'h7F;
    dp_n_d = show ? ~dp_d[idx_d] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      cnt_q      <= '0;
      scan_clk_q <= 1'b0;
      data_q     <= '0;
      dp_q       <= '0;
      blank_q    <= '0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
      dp_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      scan_clk_q <= scan_clk;
      data_q     <= data_d;
      dp_q       <= dp_d;
      blank_q    <= blank_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_n_q     <= dp_n_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp_n = dp_n_q;

endmodule
